// File: rtl/forward_hazard_unit.sv
// Forwarding-select and stall/flush generator for a 5-stage pipeline.
// Tracks the E, M and W occupants itself, so only decode fields and the EX branch outcome come in.
module forward_hazard_unit #(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             branch_taken_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  logic             e_valid_q, e_valid_d;
  logic [REG_W-1:0] e_rn_q, e_rn_d;
  logic [REG_W-1:0] e_rm_q, e_rm_d;
  logic [REG_W-1:0] e_rd_q, e_rd_d;
  logic             e_regwrite_q, e_regwrite_d;
  logic             e_memtoreg_q, e_memtoreg_d;

  logic             m_valid_q, m_valid_d;
  logic [REG_W-1:0] m_rd_q, m_rd_d;
  logic             m_regwrite_q, m_regwrite_d;
  logic             m_memtoreg_q, m_memtoreg_d;

  logic             w_valid_q, w_valid_d;
  logic [REG_W-1:0] w_rd_q, w_rd_d;
  logic             w_regwrite_q, w_regwrite_d;

  logic             lduse;
  logic             bubble_e;

  // A load in E whose result the decode instruction needs cannot be forwarded in time.
  always_comb begin
    lduse = id_valid & e_valid_q & e_memtoreg_q & e_regwrite_q
          & ((e_rd_q == id_rn) | (e_rd_q == id_rm))
          & (e_rd_q != PC_IDX);
    bubble_e = branch_taken_e | lduse;
  end

  // Control outputs are forced low while reset is held, whatever the inputs do.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!reset) begin
      stall_f = lduse & ~branch_taken_e;
      stall_d = lduse & ~branch_taken_e;
      flush_d = branch_taken_e;
      flush_e = bubble_e;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_fwd
      logic [REG_W-1:0] src;
      logic             m_hit;
      logic             w_hit;
      logic [1:0]       sel;

      assign src   = (gi == 0) ? e_rn_q : e_rm_q;
      // Loads are still in memory while in M, so only ALU results forward from there.
      assign m_hit = m_valid_q & m_regwrite_q & ~m_memtoreg_q & (m_rd_q == src);
      assign w_hit = w_valid_q & w_regwrite_q & (w_rd_q == src);
      assign sel   = ((src == PC_IDX) || !e_valid_q) ? 2'b00 :
                     m_hit                           ? 2'b10 :
                     w_hit                           ? 2'b01 : 2'b00;
    end
  endgenerate

  assign forward_a_e = gen_fwd[0].sel;
  assign forward_b_e = gen_fwd[1].sel;

  always_comb begin
    w_valid_d    = m_valid_q;
    w_rd_d       = m_rd_q;
    w_regwrite_d = m_regwrite_q;

    m_valid_d    = e_valid_q;
    m_rd_d       = e_rd_q;
    m_regwrite_d = e_regwrite_q;
    m_memtoreg_d = e_memtoreg_q;

    e_valid_d    = id_valid & ~bubble_e;
    e_rn_d       = id_rn;
    e_rm_d       = id_rm;
    e_rd_d       = id_rd;
    e_regwrite_d = id_regwrite;
    e_memtoreg_d = id_memtoreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q    <= 1'b0;
      e_rn_q       <= '0;
      e_rm_q       <= '0;
      e_rd_q       <= '0;
      e_regwrite_q <= 1'b0;
      e_memtoreg_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_rd_q       <= '0;
      m_regwrite_q <= 1'b0;
      m_memtoreg_q <= 1'b0;
      w_valid_q    <= 1'b0;
      w_rd_q       <= '0;
      w_regwrite_q <= 1'b0;
    end else begin
      e_valid_q    <= e_valid_d;
      e_rn_q       <= e_rn_d;
      e_rm_q       <= e_rm_d;
      e_rd_q       <= e_rd_d;
      e_regwrite_q <= e_regwrite_d;
      e_memtoreg_q <= e_memtoreg_d;
      m_valid_q    <= m_valid_d;
      m_rd_q       <= m_rd_d;
      m_regwrite_q <= m_regwrite_d;
      m_memtoreg_q <= m_memtoreg_d;
      w_valid_q    <= w_valid_d;
      w_rd_q       <= w_rd_d;
      w_regwrite_q <= w_regwrite_d;
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed hazard scenarios with literal expectations,
// then randomized traffic checked every cycle against an instruction-history model.
module tb_forward_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_rn, id_rm, id_rd;
  logic       id_regwrite, id_memtoreg;
  logic       branch_taken_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_d, flush_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  forward_hazard_unit #(.REG_W(4), .PC_REG(15)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .branch_taken_e(branch_taken_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e)
  );

  typedef struct {
    bit       valid;
    bit [3:0] rn, rm, rd;
    bit       wr, ld;
  } instr_t;

  // hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB.
  instr_t hist [3];

  // Last sampled DUT outputs, for the literal checks after each step.
  logic [1:0] s_fa, s_fb;
  logic       s_sf, s_sd, s_fd, s_fe;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_fwd(input bit [3:0] x);
    if (x == 4'd15 || !hist[0].valid) return 0;
    if (hist[1].valid && hist[1].wr && !hist[1].ld && hist[1].rd == x) return 2;
    if (hist[2].valid && hist[2].wr && hist[2].rd == x) return 1;
    return 0;
  endfunction

  function automatic bit model_lduse();
    return id_valid && hist[0].valid && hist[0].ld && hist[0].wr &&
           (hist[0].rd == id_rn || hist[0].rd == id_rm) && hist[0].rd != 4'd15;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) hist[i] = '{default: 0};
  endtask

  task automatic drive(input bit v, input bit [3:0] rn, input bit [3:0] rm,
                       input bit [3:0] rd, input bit wr, input bit ld, input bit br);
    id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
    id_regwrite = wr; id_memtoreg = ld; branch_taken_e = br;
  endtask

  // Called at posedge+1 with inputs already driven: sample mid-cycle, compare, advance model.
  task automatic step_check();
    bit lu, br;
    instr_t nxt;
    #4;
    s_fa = forward_a_e; s_fb = forward_b_e;
    s_sf = stall_f; s_sd = stall_d; s_fd = flush_d; s_fe = flush_e;
    lu = model_lduse();
    br = branch_taken_e;
    chk("fwd_a", s_fa, model_fwd(hist[0].rn));
    chk("fwd_b", s_fb, model_fwd(hist[0].rm));
    chk("stall_f", s_sf, int'(lu && !br));
    chk("stall_d", s_sd, int'(lu && !br));
    chk("flush_d", s_fd, int'(br));
    chk("flush_e", s_fe, int'(lu || br));
    nxt.valid = id_valid && !(lu || br);
    nxt.rn = id_rn; nxt.rm = id_rm; nxt.rd = id_rd;
    nxt.wr = id_regwrite; nxt.ld = id_memtoreg;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit v, input bit [3:0] rn, input bit [3:0] rm,
                      input bit [3:0] rd, input bit wr, input bit ld, input bit br);
    drive(v, rn, rm, rd, wr, ld, br);
    step_check();
  endtask

  task automatic rand_inputs();
    drive(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Asserts reset mid-cycle (entered at posedge+1) and holds it across one edge.
  task automatic do_reset();
    rand_inputs();
    #2 reset = 1'b1;
    #1;
    chk("rst_outs_async", int'({forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e}), 0);
    @(posedge clk); #1;
    rand_inputs();
    #3;
    chk("rst_outs_held", int'({forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit held;
    bit [3:0] pool [4];
    bit [3:0] r [3];
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    pool[0] = 4'd1; pool[1] = 4'd2; pool[2] = 4'd3; pool[3] = 4'd15;

    // Reset held with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rand_inputs();
      #3;
      chk("rst_hold_outs", int'({forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e}), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, 1, 1, 1, 1, 0, 0);
    chk("post_rst_fa", s_fa, 0);

    // ADD r1 then SUB r1: M forward.
    do_reset();
    step(1, 4, 5, 1, 1, 0, 0);
    step(1, 1, 6, 7, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lit_add_sub_m", s_fa, 2);

    // One independent instruction between: W forward.
    do_reset();
    step(1, 4, 5, 1, 1, 0, 0);
    step(1, 8, 9, 10, 1, 0, 0);
    step(1, 1, 6, 7, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lit_add_sub_w", s_fa, 1);

    // Load-use on rm: one stall, then 00, then W forward.
    do_reset();
    step(1, 4, 5, 2, 1, 1, 0);
    step(1, 6, 2, 7, 1, 0, 0);
    chk("lit_ld_stall", int'({s_sf, s_sd, s_fe}), 7);
    step(1, 6, 2, 7, 1, 0, 0);
    chk("lit_ld_nostall", int'({s_sf, s_sd, s_fe}), 0);
    chk("lit_ld_fb_bubble", s_fb, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lit_ld_fb_w", s_fb, 1);

    // M and W both write r3: M wins on both operands.
    do_reset();
    step(1, 4, 5, 3, 1, 0, 0);
    step(1, 4, 5, 3, 1, 0, 0);
    step(1, 3, 3, 7, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lit_prio_a", s_fa, 2);
    chk("lit_prio_b", s_fb, 2);

    // Branch together with load-use: branch wins.
    do_reset();
    step(1, 4, 5, 2, 1, 1, 0);
    step(1, 2, 6, 7, 1, 0, 1);
    chk("lit_br_flush", int'({s_fd, s_fe}), 3);
    chk("lit_br_nostall", int'({s_sf, s_sd}), 0);
    step(1, 2, 2, 8, 1, 0, 0);
    chk("lit_br_bubble", int'({s_fa, s_fb, s_sf, s_fe}), 0);

    // r15 is never forwarded nor stalled on, even after a load.
    do_reset();
    step(1, 4, 5, 15, 1, 1, 0);
    step(1, 15, 15, 7, 1, 0, 0);
    chk("lit_pc_nostall", int'({s_sf, s_sd, s_fe}), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lit_pc_fwd", int'({s_fa, s_fb}), 0);

    // Randomized traffic over a small register pool, decode held while stalled.
    do_reset();
    held = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        held = 1'b0;
      end
      if (!held) begin
        for (int k = 0; k < 3; k++)
          r[k] = ($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 3)] : 4'($urandom);
        drive(($urandom_range(0, 9) < 8), r[0], r[1], r[2],
              1'($urandom), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0));
      end else begin
        branch_taken_e = ($urandom_range(0, 9) == 0);
      end
      held = model_lduse() && !branch_taken_e;
      step_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
